// File: rtl/mod_reduce_serial_if.sv
//------------------------------------------------------------------------------
// mod_reduce_serial_if : operand/residue handshake bundle for mod_reduce_serial
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mod_reduce_serial_if #(
  parameter int DATA_W = 30,
  parameter int RES_W  = 7
);
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_res;
  logic              busy;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_res, busy
  );
endinterface

`default_nettype wire

// File: rtl/mod_reduce_serial.sv
//------------------------------------------------------------------------------
// mod_reduce_serial : serial Horner-order reduction of an operand modulo MOD,
//                     CHUNK_W bits per cycle. Optional macro MOD_REDUCE_ZERO_FLAG_EN
//                     adds the res_zero output.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_reduce_serial #(
  parameter int MOD     = 113,
  parameter int DATA_W  = 30,
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 7
) (
  input  wire                 clk,
  input  wire                 rst_n,
  mod_reduce_serial_if.slave  bus
`ifdef MOD_REDUCE_ZERO_FLAG_EN
  ,
  output logic                res_zero
`endif
);

  localparam int c_nchunk = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int c_pad_w  = c_nchunk * CHUNK_W;
  localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
  localparam int c_sum_w  = RES_W + CHUNK_W;
  localparam logic [c_sum_w-1:0] c_mod = c_sum_w'(MOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic [c_pad_w-1:0]   r_data;
  logic [RES_W-1:0]     r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [RES_W-1:0]     r_res;
  logic [CHUNK_W-1:0]   w_chunk;
  logic [c_sum_w-1:0]   w_sum;
  logic [RES_W-1:0]     w_acc_next;

  // The operand shifts left each RUN cycle, so the chunk being consumed is
  // always the top slice; acc < MOD keeps acc*2^CHUNK_W + chunk within c_sum_w.
  assign w_chunk    = r_data[c_pad_w-1 -: CHUNK_W];
  assign w_sum      = {r_acc, w_chunk};
  assign w_acc_next = RES_W'(w_sum % c_mod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Abort overrides every handshake on the same edge.
    if (bus.clr) begin
      w_state_next = S_IDLE;
      w_accept     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_res  <= '0;
    end else if (!bus.clr) begin
      if (w_accept) begin
        r_data <= c_pad_w'(bus.in_data);
        r_acc  <= '0;
        r_cnt  <= c_cnt_w'(c_nchunk - 1);
      end else if (r_state == S_RUN) begin
        r_data <= r_data << CHUNK_W;
        r_acc  <= w_acc_next;
        if (r_cnt == '0) begin
          r_res <= w_acc_next;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.out_res = r_res;

`ifdef MOD_REDUCE_ZERO_FLAG_EN
  assign res_zero = (r_state == S_DONE) && (r_res == '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_reduce_serial.sv
//------------------------------------------------------------------------------
// tb_mod_reduce_serial : randomized self-checking bench for mod_reduce_serial
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_reduce_serial;
  localparam int MOD     = 113;
  localparam int DATA_W  = 30;
  localparam int CHUNK_W = 6;
  localparam int RES_W   = 7;
  localparam int NCHUNK  = 5;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mod_reduce_serial_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

`ifdef MOD_REDUCE_ZERO_FLAG_EN
  logic res_zero;
`endif

  mod_reduce_serial #(
    .MOD(MOD), .DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .RES_W(RES_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef MOD_REDUCE_ZERO_FLAG_EN
    ,
    .res_zero (res_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [RES_W-1:0] ref_mod(input longint d);
    return RES_W'(d % MOD);
  endfunction

  task automatic check_res_zero(input logic [RES_W-1:0] exp);
`ifdef MOD_REDUCE_ZERO_FLAG_EN
    n_vec++;
    if (res_zero !== (exp == '0)) begin
      n_err++;
      $display("FAIL res_zero: got %b expected %b", res_zero, (exp == '0));
    end
`else
    if (exp === 'x) $display("unexpected unknown expectation");
`endif
  endtask

  task automatic run_op(input logic [DATA_W-1:0] d);
    int lat;
    logic [RES_W-1:0] exp;
    exp = ref_mod(longint'(d));
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL op_in_ready: got %b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      n_vec++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL op_busy: busy=%b in_ready=%b expected 1/0", bus.busy, bus.in_ready);
      end
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat != NCHUNK) begin
      n_err++;
      $display("FAIL op_latency: data=%0d got %0d expected %0d", d, lat, NCHUNK);
    end
    n_vec++;
    if (bus.out_res !== exp) begin
      n_err++;
      $display("FAIL op_result: data=%0d got %0d expected %0d", d, bus.out_res, exp);
    end
    check_res_zero(exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL op_release: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_res !== '0) begin
      n_err++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_res=%0d expected 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_res);
    end
    check_res_zero(7'd1);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [DATA_W-1:0] vals [8];
    vals = '{30'd500, 30'h3FFFFFFF, 30'd113, 30'd112, 30'd0, 30'd226, 30'd1, 30'd12769};
    foreach (vals[i]) run_op(vals[i]);
  endtask

  task automatic test_backpressure();
    int w;
    logic [RES_W-1:0] exp;
    exp = ref_mod(longint'(777));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 30'd777;
    @(negedge clk);
    bus.in_valid = 1'b0;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    bus.in_valid = 1'b1; bus.in_data = 30'd5;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_res !== exp || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: cyc=%0d out_valid=%b out_res=%0d in_ready=%b busy=%b expected 1/%0d/0/0",
                 i, bus.out_valid, bus.out_res, bus.in_ready, bus.busy, exp);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_accept_on_handshake: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_clr();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 30'd999_999;
    @(negedge clk);               // after accept edge
    bus.in_valid = 1'b0;
    @(negedge clk);               // after RUN edge 1
    @(negedge clk);               // after RUN edge 2
    bus.clr = 1'b1;               // held through RUN edge 3
    @(negedge clk);
    bus.clr = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clr_run: busy=%b in_ready=%b out_valid=%b expected 0/1/0",
               bus.busy, bus.in_ready, bus.out_valid);
    end
    seen = 0;
    repeat (8) begin @(negedge clk); if (bus.out_valid === 1'b1) seen++; end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL clr_no_output: got %0d valid cycles expected 0", seen);
    end
    run_op(30'd226);
    // Abort while a residue waits in DONE.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 30'd4242;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 0;
    while (bus.out_valid !== 1'b1 && seen < 40) begin @(negedge clk); seen++; end
    bus.clr = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clr_done: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    run_op(30'd500);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 30'd123456;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_res !== '0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b in_ready=%b out_valid=%b out_res=%0d expected 0/1/0/0",
               bus.busy, bus.in_ready, bus.out_valid, bus.out_res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (bus.out_valid === 1'b1) seen++; end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL async_reset_stale: got %0d valid cycles expected 0", seen);
    end
    run_op(30'd113);
  endtask

  task automatic test_random();
    logic [RES_W-1:0] q[$];
    logic [RES_W-1:0] got;
    logic [DATA_W-1:0] d;
    int results;
    int w;
    bit r;
    results = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 9))
        0:       d = '1;
        1:       d = DATA_W'(MOD * $urandom_range(0, 1000));
        default: d = DATA_W'($urandom);
      endcase
      if (bus.in_ready !== 1'b1) begin
        n_vec++; n_err++;
        $display("FAIL rnd_in_ready: op=%0d got %b expected 1", i, bus.in_ready);
      end
      bus.in_valid = 1'b1; bus.in_data = d;
      q.push_back(ref_mod(longint'(d)));
      @(negedge clk);
      bus.in_valid = 1'b0;
      w = 0;
      while (bus.out_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      got = bus.out_res;
      n_vec++;
      if (bus.out_valid !== 1'b1 || q.size() == 0 || got !== q[0]) begin
        n_err++;
        $display("FAIL rnd_result: op=%0d data=%0d got %0d expected %0d", i, d, got,
                 (q.size() != 0) ? q[0] : 7'd0);
      end
      if (q.size() != 0) void'(q.pop_front());
      results++;
      w = 0;
      do begin
        r = (w > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.out_ready = r;
        @(negedge clk);
        w++;
        if (!r && (bus.out_valid !== 1'b1 || bus.out_res !== got)) begin
          n_vec++; n_err++;
          $display("FAIL rnd_hold: op=%0d out_valid=%b out_res=%0d expected 1/%0d",
                   i, bus.out_valid, bus.out_res, got);
        end
      end while (!r);
      bus.out_ready = 1'b0;
      if (bus.out_valid !== 1'b0) begin
        n_vec++; n_err++;
        $display("FAIL rnd_dup: op=%0d out_valid=%b expected 0", i, bus.out_valid);
      end
    end
    n_vec++;
    if (results != 1000 || q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_count: results=%0d pending=%0d expected 1000/0", results, q.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_clr();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_reduce_serial.md
MOD_REDUCE_SERIAL -- requirements
Module: mod_reduce_serial

Interface
REQ-001 SHALL have parameter MOD, default 113, the modulus; legal range 2..2^RES_W-1.
REQ-002 SHALL have parameter DATA_W, default 30, the operand width in bits.
REQ-003 SHALL have parameter CHUNK_W, default 6, the bits consumed per cycle.
REQ-004 SHALL have parameter RES_W, default 7, the residue width, with MOD < 2^RES_W.
REQ-005 SHALL define NCHUNK = ceil(DATA_W/CHUNK_W) and zero-extend the operand at the MSB end to NCHUNK*CHUNK_W bits.
REQ-006 SHALL have ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clr  in  1  synchronous abort.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when both in_valid and in_ready are high.
- in_data  in  DATA_W  operand.
- out_valid  out  1  residue valid.
- out_ready  in  1  consumer ready.
- out_res  out  RES_W  the value in_data mod MOD.
- busy  out  1  high in RUN.

Function
REQ-007 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-008 SHALL hold in_ready=1 only in IDLE and 0 in RUN and DONE.
REQ-009 On an accept edge (IDLE, in_valid=1), SHALL capture in_data, clear acc to 0, load chunk counter=NCHUNK-1, and go to RUN.
REQ-010 On each RUN edge, SHALL update acc = (acc*2^CHUNK_W + chunk[cnt]) mod MOD, starting from the most significant chunk (Horner order); acc SHALL stay below MOD.
REQ-011 SHALL go to DONE on the edge that processes chunk 0, with out_res=acc; latency is exactly NCHUNK edges from accept to out_valid=1.
REQ-012 SHALL hold out_valid=1 in DONE, with out_res stable until the edge on which out_ready=1, then return to IDLE.
REQ-013 SHALL NOT accept an operand on the same edge as the output handshake; the next accept occurs at the earliest on the following edge, giving a throughput of 1 per NCHUNK+2 cycles.
REQ-014 SHALL have the reduction step fully combinational within one cycle, with no multicycle paths.
REQ-015 clr=1 SHALL force IDLE on the next edge from any state, discarding any operand or residue, and SHALL take priority over every handshake on that edge.
REQ-016 SHALL hold out_res at its last value while out_valid=0; consumers SHALL ignore it.
REQ-017 SHALL drive busy=1 exactly while in RUN.

Reset
REQ-018 On rst_n=0, SHALL immediately put the block in IDLE with acc=0, counter=0, out_res=0, out_valid=0, busy=0 and in_ready=1.
REQ-019 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; there is no residue output after release.
REQ-020 SHALL deassert reset synchronously to clk (external synchroniser); the first accept is legal on the first edge after release.

Configuration
REQ-021 With macro MOD_REDUCE_ZERO_FLAG_EN defined, SHALL add output port res_zero (1 bit), equal to (out_res==0) while out_valid=1 and 0 otherwise, and reset to 0.
REQ-022 Without MOD_REDUCE_ZERO_FLAG_EN, the res_zero port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults MOD=113, DATA_W=30, CHUNK_W=6, NCHUNK=5)
REQ-023 in_data=500 accepted at edge E0 -> out_valid=1 after E5, out_res=48.
REQ-024 in_data=0x3FFFFFFF -> out_res=3; in_data=113 -> 0 (res_zero=1 when enabled); in_data=112 -> 112.
REQ-025 out_ready held 0 for 10 cycles in DONE -> out_valid and out_res stable; in_ready=0 throughout; in_valid asserted during this time is not accepted.
REQ-026 clr=1 at the 3rd RUN edge -> IDLE on next edge, no out_valid; a new operand 226 then gives out_res=0.
REQ-027 rst_n pulsed low asynchronously mid-RUN -> outputs reach reset values without a clock edge; no stale residue appears after release.
REQ-028 1000 random operands with random out_ready back-pressure -> every out_res equals in_data mod 113, in order, with no loss or duplication.
